// File: rtl/switch_word_loader.sv
// rtl/switch_word_loader.sv - front-panel hex word entry and RAM load write handshake
//
// Purpose: conditions two raw push buttons (digit, commit), assembles a 32-bit
// word one hex nibble at a time from sw_nibble, and on commit issues a write
// to the RAM load port at an auto-incrementing word address.
//
// Ports:
//   clock, reset      single clock domain, synchronous active-high reset
//   key_digit_n       raw active-low button, shifts sw_nibble into word_out
//   key_commit_n      raw active-low button, writes word_out to RAM
//   sw_nibble [3:0]   hex digit sampled on the digit press pulse
//   wr_ready          RAM accepts on an edge where wr_en && wr_ready
//   wr_en             write request, held until accepted
//   wr_addr [ADDR_W]  word address of the current/next write
//   wr_data [31:0]    word being written, stable while wr_en = 1
//   word_out [31:0]   word under construction, for display
//   digit_count [3:0] nibbles entered since last clear, saturates at 8
//   busy              high while a write is outstanding

module switch_word_loader #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int ADDR_W          = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              key_digit_n,
    input  logic              key_commit_n,
    input  logic [3:0]        sw_nibble,
    input  logic              wr_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic [31:0]       word_out,
    output logic [3:0]        digit_count,
    output logic              busy
);

    localparam logic [15:0] DB_LAST = 16'(DEBOUNCE_CYCLES - 1);

    // Index 0 = digit key, index 1 = commit key.
    logic [1:0]  raw_n;
    logic [1:0]  sync1;
    logic [1:0]  sync2;
    logic [1:0]  db;
    logic [1:0]  db_d;
    logic [1:0]  pulse;
    logic [15:0] stable_cnt [2];

    assign raw_n = {key_commit_n, key_digit_n};

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1         <= 2'b11;
            sync2         <= 2'b11;
            db            <= 2'b11;
            db_d          <= 2'b11;
            pulse         <= 2'b00;
            stable_cnt[0] <= 16'd0;
            stable_cnt[1] <= 16'd0;
        end else begin
            sync1 <= raw_n;
            sync2 <= sync1;
            db_d  <= db;
            // Falling edge of the debounced level, registered once more so the
            // press pulse is a clean one-cycle flop output.
            pulse <= db_d & ~db;
            for (int k = 0; k < 2; k++) begin
                if (sync2[k] != db[k]) begin
                    if (stable_cnt[k] == DB_LAST) begin
                        db[k]         <= sync2[k];
                        stable_cnt[k] <= 16'd0;
                    end else begin
                        stable_cnt[k] <= stable_cnt[k] + 16'd1;
                    end
                end else begin
                    stable_cnt[k] <= 16'd0;
                end
            end
        end
    end

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

    state_t            state, state_next;
    logic [ADDR_W-1:0] addr_next;
    logic [31:0]       data_next;
    logic [31:0]       word_next;
    logic [3:0]        count_next;

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            wr_addr     <= '0;
            wr_data     <= 32'd0;
            word_out    <= 32'd0;
            digit_count <= 4'd0;
        end else begin
            state       <= state_next;
            wr_addr     <= addr_next;
            wr_data     <= data_next;
            word_out    <= word_next;
            digit_count <= count_next;
        end
    end

    always_comb begin
        state_next = state;
        addr_next  = wr_addr;
        data_next  = wr_data;
        word_next  = word_out;
        count_next = digit_count;
        case (state)
            IDLE: begin
                // Commit has priority; a digit pulse in the same cycle is dropped.
                if (pulse[1]) begin
                    data_next  = word_out;
                    state_next = WRITE;
                end else if (pulse[0]) begin
                    word_next  = {word_out[27:0], sw_nibble};
                    count_next = (digit_count >= 4'd8) ? 4'd8 : digit_count + 4'd1;
                end
            end
            WRITE: begin
                // Key pulses are ignored here, not queued.
                if (wr_ready) begin
                    state_next = IDLE;
                    addr_next  = wr_addr + ADDR_W'(1);
                    word_next  = 32'd0;
                    count_next = 4'd0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // The state register itself drives these, so they remain flop outputs.
    assign busy  = (state == WRITE);
    assign wr_en = (state == WRITE);

endmodule

// File: tb/tb_switch_word_loader.sv
// tb/tb_switch_word_loader.sv - self-checking bench for switch_word_loader
module tb_switch_word_loader;

    localparam int DB = 4;
    localparam int AW = 2;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          key_digit_n = 1'b1;
    logic          key_commit_n = 1'b1;
    logic [3:0]    sw_nibble = 4'd0;
    logic          wr_ready = 1'b1;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [31:0]   wr_data;
    logic [31:0]   word_out;
    logic [3:0]    digit_count;
    logic          busy;

    always #5 clock = ~clock;

    switch_word_loader #(.DEBOUNCE_CYCLES(DB), .ADDR_W(AW)) dut (
        .clock(clock), .reset(reset),
        .key_digit_n(key_digit_n), .key_commit_n(key_commit_n),
        .sw_nibble(sw_nibble), .wr_ready(wr_ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .word_out(word_out), .digit_count(digit_count), .busy(busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: a key level is accepted once the last DB synchronized
    // samples all disagree with the accepted level; a press is an accepted
    // 1->0 change, seen by the word logic two edges later.
    bit [1:0]      ms1, ms2, mdb, mfell, mpul, samp, newfell;
    bit            win0[$];
    bit            win1[$];
    bit            m_busy;
    logic [AW-1:0] m_addr;
    logic [31:0]   m_data, m_word;
    logic [3:0]    m_cnt;
    logic [31:0]   mw_data[$];
    int            mw_addr[$];
    bit            model_ok = 1'b0;
    bit            rand_ready = 1'b0;

    function automatic bit all_differ(input bit q[$], input bit v);
        foreach (q[i]) if (q[i] == v) return 1'b0;
        return 1'b1;
    endfunction

    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (reset) begin
                ms1 = 2'b11; ms2 = 2'b11; mdb = 2'b11; mfell = 2'b00; mpul = 2'b00;
                win0.delete(); win1.delete();
                m_busy = 1'b0; m_addr = '0; m_data = 32'd0; m_word = 32'd0; m_cnt = 4'd0;
            end else begin
                if (m_busy) begin
                    if (wr_ready) begin
                        mw_data.push_back(m_data);
                        mw_addr.push_back(int'(m_addr));
                        m_busy = 1'b0;
                        m_addr = m_addr + 1'b1;
                        m_word = 32'd0;
                        m_cnt  = 4'd0;
                    end
                end else if (mpul[1]) begin
                    m_data = m_word;
                    m_busy = 1'b1;
                end else if (mpul[0]) begin
                    m_word = m_word * 16 + 32'(sw_nibble);
                    m_cnt  = (m_cnt < 4'd8) ? m_cnt + 4'd1 : 4'd8;
                end
                mpul = mfell;
                samp = ms2;
                ms2  = ms1;
                ms1  = {key_commit_n, key_digit_n};
                win0.push_back(samp[0]); if (win0.size() > DB) void'(win0.pop_front());
                win1.push_back(samp[1]); if (win1.size() > DB) void'(win1.pop_front());
                newfell = 2'b00;
                if (win0.size() == DB && all_differ(win0, mdb[0])) begin
                    mdb[0] = samp[0]; newfell[0] = ~samp[0];
                end
                if (win1.size() == DB && all_differ(win1, mdb[1])) begin
                    mdb[1] = samp[1]; newfell[1] = ~samp[1];
                end
                mfell = newfell;
            end
            model_ok = 1'b1;
        end
    end

    // Every cycle, every output against the model.
    initial begin
        forever begin
            @(negedge clock);
            if (model_ok)
                chk("cycle_outputs",
                    {wr_en, busy, wr_addr, wr_data, word_out, digit_count},
                    {m_busy, m_busy, m_addr, m_data, m_word, m_cnt});
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clock);
            if (rand_ready) wr_ready = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic press(input bit which, input logic [3:0] nib, input int hold, input int rel);
        sw_nibble = nib;
        if (which) key_commit_n = 1'b0; else key_digit_n = 1'b0;
        cyc(hold);
        key_commit_n = 1'b1;
        key_digit_n  = 1'b1;
        cyc(rel);
    endtask

    initial begin
        @(negedge clock);
        cyc(3);
        reset = 1'b0;
        chk("reset_outputs", {wr_en, busy, wr_addr, wr_data, word_out, digit_count}, 0);
        cyc(2);

        // Eight nibbles then commit.
        for (int i = 1; i <= 8; i++) press(1'b0, 4'(i), DB + 6, DB + 6);
        chk("digits_word", word_out, 32'h12345678);
        press(1'b1, 4'd0, DB + 6, DB + 6);
        chk("write1_model_data", mw_data[0], 32'h12345678);
        chk("write1_model_addr", mw_addr[0], 0);
        chk("after_write1", {wr_addr, word_out, digit_count}, {2'd1, 32'd0, 4'd0});

        // Glitch of 3 samples, then a held press with exact latency.
        key_digit_n = 1'b0; sw_nibble = 4'h9;
        cyc(3);
        key_digit_n = 1'b1;
        cyc(10);
        key_digit_n = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            cyc(1);
            if (i == 7) chk("latency_before", digit_count, 4'd0);
            if (i == 8) chk("latency_after", digit_count, 4'd1);
        end
        cyc(12);
        key_digit_n = 1'b1;
        cyc(10);
        chk("single_pulse", {word_out, digit_count}, {32'h9, 4'd1});

        // Overflow: ten more nibbles keep the newest eight.
        begin
            logic [3:0] seq [10] = '{4'hA, 4'hB, 4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7};
            foreach (seq[i]) press(1'b0, seq[i], DB + 6, DB + 6);
        end
        chk("overflow_model", {m_word, m_cnt}, {32'h01234567, 4'd8});
        chk("overflow_dut", {word_out, digit_count}, {32'h01234567, 4'd8});
        press(1'b1, 4'd0, DB + 6, DB + 6);

        // Backpressure with a digit press during the stalled write.
        press(1'b0, 4'h5, DB + 6, DB + 6);
        wr_ready = 1'b0;
        press(1'b1, 4'd0, DB + 6, DB + 6);
        chk("stalled_write", {wr_en, wr_data}, {1'b1, 32'h5});
        press(1'b0, 4'hC, DB + 6, DB + 6);
        chk("stalled_still", {wr_en, wr_data, word_out}, {1'b1, 32'h5, 32'h5});
        wr_ready = 1'b1;
        cyc(3);
        chk("bp_model_data", mw_data[mw_data.size()-1], 32'h5);
        chk("bp_after", {wr_en, word_out, digit_count}, {1'b0, 32'd0, 4'd0});

        // Address wrap with empty commits, starting from address 0.
        reset = 1'b1; cyc(1); reset = 1'b0; cyc(2);
        for (int i = 0; i < 4; i++) press(1'b1, 4'd0, DB + 6, DB + 6);
        for (int i = 0; i < 4; i++) begin
            chk("wrap_model_addr", mw_addr[mw_addr.size()-4+i], i);
            chk("wrap_model_data", mw_data[mw_data.size()-4+i], 32'd0);
        end
        chk("wrap_addr", wr_addr, 2'd0);

        // Reset aborts a stalled write.
        press(1'b0, 4'h7, DB + 6, DB + 6);
        wr_ready = 1'b0;
        press(1'b1, 4'd0, DB + 6, DB + 6);
        chk("abort_pending", busy, 1'b1);
        reset = 1'b1; cyc(1); reset = 1'b0;
        chk("abort_outputs", {wr_en, busy, wr_addr, wr_data, word_out, digit_count}, 0);
        wr_ready = 1'b1;
        cyc(3);

        // Both keys together: commit wins with the prior word.
        press(1'b0, 4'h3, DB + 6, DB + 6);
        sw_nibble = 4'hE; key_digit_n = 1'b0; key_commit_n = 1'b0;
        cyc(DB + 6);
        key_digit_n = 1'b1; key_commit_n = 1'b1;
        cyc(DB + 6);
        chk("simul_model_data", mw_data[mw_data.size()-1], 32'h3);
        chk("simul_after", {word_out, digit_count}, {32'd0, 4'd0});

        // Randomized mix: glitches, presses of any length, random wr_ready.
        rand_ready = 1'b1;
        for (int i = 0; i < 60; i++) begin
            press(1'($urandom_range(0, 3) == 0), 4'($urandom_range(0, 15)),
                  $urandom_range(1, DB + 8), $urandom_range(1, DB + 8));
        end
        rand_ready = 1'b0;
        wr_ready = 1'b1;
        cyc(20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/switch_word_loader.md
# switch_word_loader

Front-panel entry block for loading program/data words into the MIPS instruction or data RAM from board switches and push buttons. It is the input-side counterpart of the register/display readout path: the operator keys in a 32-bit word one hex nibble at a time, then commits it, and the block issues a write handshake to the RAM load port at an auto-incrementing word address. It sits between the board I/O (KEY/SW) and the RAM load interface in the FPGA top level, and exposes the word under construction for the seven-segment display decoders.

## Interface

Parameters:
- DEBOUNCE_CYCLES, 16, number of consecutive stable synchronized samples required before a key change is accepted; legal range 1..65535.
- ADDR_W, 8, width of the word address.

Ports:
- clock  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- key_digit_n  in  1  raw push button, active-low (0 = pressed), asynchronous; shifts in a nibble.
- key_commit_n  in  1  raw push button, active-low, asynchronous; writes the assembled word.
- sw_nibble  in  4  hex digit to shift in; sampled on the digit press pulse.
- wr_ready  in  1  RAM accepts the write on an edge where wr_en && wr_ready.
- wr_en  out  1  write request; held until accepted.
- wr_addr  out  ADDR_W  word address of the current/next write.
- wr_data  out  32  word being written; stable while wr_en = 1.
- word_out  out  32  word under construction, for display.
- digit_count  out  4  nibbles entered since last clear, 0..8, saturating.
- busy  out  1  1 while in state WRITE.

## Operation

- Key conditioning (per key, independent): 2-flop synchronizer (reset value 1), then debouncer with a stable counter; counter increments on each edge where the synchronized value differs from the debounced state and clears when equal. On the edge where it differs and the counter equals DEBOUNCE_CYCLES-1, the debounced state takes the synchronized value and the counter clears. Debounced state resets to 1 (released).
- Press pulse: registered, one cycle high on the debounced 1->0 transition only. Release generates nothing. Holding a key produces exactly one pulse.
- State machine, reset state IDLE:
  - IDLE, commit pulse: wr_data <= word_out, wr_en <= 1, go to WRITE. Commit is accepted at any digit_count, including 0, where it writes 0x00000000.
  - IDLE, digit pulse (no commit pulse): word_out <= {word_out[27:0], sw_nibble}; digit_count <= min(digit_count+1, 8). A 9th and later nibble still shifts; oldest nibble is lost.
  - IDLE, both pulses in the same cycle: commit wins, digit pulse is dropped.
  - WRITE: hold wr_en, wr_addr, wr_data. On the edge where wr_ready = 1: wr_en <= 0, wr_addr <= wr_addr + 1 (mod 2^ADDR_W; all-ones wraps to 0), word_out <= 0, digit_count <= 0, go to IDLE.
  - WRITE: digit and commit pulses are discarded (not queued).
- Reset values: wr_en 0, wr_addr 0, wr_data 0, word_out 0, digit_count 0, busy 0, state IDLE, all debounce counters 0. Reset during WRITE aborts the write; wr_en falls on the reset edge and the address does not advance.

## Timing

- Key latency: a raw key held low from before edge E yields its press pulse high in the cycle after edge E+DEBOUNCE_CYCLES+2, which is DEBOUNCE_CYCLES+3 edges. Glitches shorter than DEBOUNCE_CYCLES synchronized samples produce no pulse.
- Digit pulse high in cycle C: word_out and digit_count are updated at the end of C and visible in C+1.
- Commit pulse high in cycle C: wr_en = 1 and busy = 1 from C+1.
- With wr_ready tied high, wr_en is high for exactly 1 cycle, C+1. wr_addr increments and word_out clears in C+2.
- Each wr_ready = 0 cycle during WRITE adds one cycle. wr_en never deasserts without acceptance, except on reset.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan

- Entry and write, DEBOUNCE_CYCLES=4, wr_ready=1: press digit with nibbles 1,2,3,4,5,6,7,8, then commit -> one wr_en pulse with wr_addr=0, wr_data=0x12345678; then wr_addr=1, word_out=0, digit_count=0.
- Debounce: pulse key_digit_n low for 3 cycles, then hold it low for 20 cycles -> no pulse from the first; exactly one digit pulse, DEBOUNCE_CYCLES+3=7 edges after the hold starts; digit_count=1.
- Overflow: 10 digit presses of A,B,0,1,2,3,4,5,6,7 -> word_out=0x01234567, digit_count=8.
- Backpressure: commit with wr_ready=0 for 5 cycles, pressing digit meanwhile -> wr_en and wr_data stable for 6 cycles; write accepted on the first wr_ready=1 edge; digit press lost; word_out=0 afterwards.
- Wrap and empty commit: ADDR_W=2, four commits with no digits -> four writes of 0x00000000 at addresses 0,1,2,3; wr_addr returns to 0.
- Reset mid-write and simultaneous keys: reset asserted while wr_en=1 and wr_ready=0 -> next cycle all outputs 0, no write accepted. Digit and commit pulses in the same cycle -> the write carries the prior word_out; nibble not shifted.
